// File: rtl/br_lite_local_if.sv
// rtl/br_lite_local_if.sv - BrLite PE-to-router local-port interface
// TX FIFO with req/ack injector gated by router busy, RX FIFO draining the router.
package br_lite_pkg;
  typedef logic [15:0] br_data_t;
endpackage

module br_lite_local_if
  import br_lite_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  br_data_t                  pe_tx_data_i,
  input  logic                      pe_tx_valid_i,
  output logic                      pe_tx_ready_o,
  output br_data_t                  pe_rx_data_o,
  output logic                      pe_rx_valid_o,
  input  logic                      pe_rx_ready_i,
  output br_data_t                  noc_flit_o,
  output logic                      noc_req_o,
  input  logic                      noc_ack_i,
  input  br_data_t                  noc_flit_i,
  input  logic                      noc_req_i,
  output logic                      noc_ack_o,
  input  logic                      noc_busy_i,
  output logic [$clog2(TX_DEPTH):0] tx_level_o,
  output logic [$clog2(RX_DEPTH):0] rx_level_o
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef enum logic {IDLE, REQ} tx_state_t;

  br_data_t         tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr;
  logic [TX_AW:0]   tx_level;
  logic [TX_AW:0]   tx_level_nxt;
  logic             tx_full;
  logic             tx_push;
  logic             tx_pop;
  tx_state_t        tx_state;
  logic             tx_req;

  br_data_t         rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr;
  logic [RX_AW-1:0] rx_rd_ptr;
  logic [RX_AW:0]   rx_level;
  logic             rx_full;
  logic             rx_push;
  logic             rx_pop;

  assign tx_full       = (tx_level == (TX_AW + 1)'(TX_DEPTH));
  assign pe_tx_ready_o = !tx_full && !rst_i;
  assign tx_push       = pe_tx_valid_i && pe_tx_ready_o;
  assign tx_pop        = tx_req && noc_ack_i;
  assign noc_flit_o    = tx_mem[tx_rd_ptr];
  assign noc_req_o     = tx_req;
  assign tx_level_o    = tx_level;

  always_comb begin
    tx_level_nxt = tx_level;
    if (tx_push && !tx_pop)
      tx_level_nxt = tx_level + (TX_AW + 1)'(1);
    else if (tx_pop && !tx_push)
      tx_level_nxt = tx_level - (TX_AW + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (tx_push)
      tx_mem[tx_wr_ptr] <= pe_tx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push)
        tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)
        tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      tx_level <= tx_level_nxt;
    end
  end

  // Busy only gates the start of an injection; an outstanding req is held until ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state <= IDLE;
      tx_req   <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_level != '0 && !noc_busy_i) begin
            tx_state <= REQ;
            tx_req   <= 1'b1;
          end
        end
        REQ: begin
          if (noc_ack_i && (tx_level_nxt == '0 || noc_busy_i)) begin
            tx_state <= IDLE;
            tx_req   <= 1'b0;
          end
        end
        default: begin
          tx_state <= IDLE;
          tx_req   <= 1'b0;
        end
      endcase
    end
  end

  assign rx_full       = (rx_level == (RX_AW + 1)'(RX_DEPTH));
  assign noc_ack_o     = !rx_full && !rst_i;
  assign rx_push       = noc_req_i && noc_ack_o;
  assign pe_rx_valid_o = (rx_level != '0);
  assign rx_pop        = pe_rx_valid_o && pe_rx_ready_i;
  assign pe_rx_data_o  = rx_mem[rx_rd_ptr];
  assign rx_level_o    = rx_level;

  always_ff @(posedge clk_i) begin
    if (rx_push)
      rx_mem[rx_wr_ptr] <= noc_flit_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_push)
        rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)
        rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      if (rx_push && !rx_pop)
        rx_level <= rx_level + (RX_AW + 1)'(1);
      else if (rx_pop && !rx_push)
        rx_level <= rx_level - (RX_AW + 1)'(1);
    end
  end

endmodule
